// File: rtl/fifo_burst_reader.sv
// Purpose: drains a show-ahead FIFO read port in fixed-length bursts onto a registered valid/ready stream with sop/eop.
// Latency: avail >= BURST_LEN in cycle N -> first pop in N+1 -> first valid_o (with sop_o) in N+2; one word/cycle after that.
// Backpressure: pops only while the output register is free or being accepted; data/sop/eop hold while valid_o && !ready_i.
//
// Optional feature macro: FLUSH_TIMEOUT_EN -- adds an idle timer (parameter TIMEOUT_CYCLES)
// that flushes a partial burst of 1..BURST_LEN-1 words. The parameter exists only in that build.
//
// Ports:
//   clk_i / rst_i        FIFO read clock, asynchronous active-high reset
//   fifo_data_i          show-ahead FIFO head word, valid while !fifo_empty_i
//   fifo_empty_i         FIFO empty flag
//   fifo_used_words_i    FIFO word count, excluding the presented head word
//   fifo_rd_o            pop request for the presented word
//   data_o/valid_o/ready_i  output stream
//   sop_o / eop_o        first / last word of a burst, qualified by valid_o
//   busy_o               burst in progress or output register occupied
module fifo_burst_reader #(
   parameter int DATA_WIDTH   = 8,
   parameter int WORDS_AMOUNT = 8,
   parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
   parameter int BURST_LEN    = 4
`ifdef FLUSH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   input  logic                  fifo_empty_i,
   input  logic [ADDR_WIDTH:0]   fifo_used_words_i,
   output logic                  fifo_rd_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  sop_o,
   output logic                  eop_o,
   output logic                  busy_o
);

   // Counter width matches the available-word count so every compare is same-width.
   localparam int CW = ADDR_WIDTH + 2;
   localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         len_q, len_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  sop_q, sop_d;
   logic                  eop_q, eop_d;
   logic [CW-1:0]         avail;
   logic                  last_word;
   logic                  pop;

`ifdef FLUSH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]         timer_q, timer_d;
`endif

   // The head word sits outside fifo_used_words_i, so add it back; one extra bit avoids overflow.
   assign avail     = {1'b0, fifo_used_words_i} + {{(CW-1){1'b0}}, ~fifo_empty_i};
   assign last_word = (cnt_q == len_q - CNT_ONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      data_d  = data_q;
      valid_d = valid_q;
      sop_d   = sop_q;
      eop_d   = eop_q;
      pop     = 1'b0;
`ifdef FLUSH_TIMEOUT_EN
      timer_d = timer_q;
`endif

      // Accepted word leaves the register; a pop below reloads it in the same cycle.
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // No pop in the evaluation cycle; a full burst wins over a timeout flush.
            if (avail >= BURST_LEN_C) begin
               state_d = BURST;
               len_d   = BURST_LEN_C;
               cnt_d   = '0;
`ifdef FLUSH_TIMEOUT_EN
               timer_d = '0;
`endif
            end
`ifdef FLUSH_TIMEOUT_EN
            else if (fifo_empty_i) begin
               timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
               state_d = BURST;
               len_d   = avail;
               cnt_d   = '0;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
`endif
         end
         BURST: begin
            pop = !fifo_empty_i && (!valid_q || ready_i);
            if (pop) begin
               data_d  = fifo_data_i;
               valid_d = 1'b1;
               sop_d   = (cnt_q == '0);
               eop_d   = last_word;
               cnt_d   = cnt_q + CNT_ONE;
               if (last_word) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= BURST_LEN_C;
         data_q  <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
`ifdef FLUSH_TIMEOUT_EN
         timer_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
`ifdef FLUSH_TIMEOUT_EN
         timer_q <= timer_d;
`endif
      end
   end

   assign fifo_rd_o = pop;
   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign sop_o     = sop_q;
   assign eop_o     = eop_q;
   assign busy_o    = (state_q == BURST) || valid_q;

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side consumer for the dual-clock FIFO. It runs in the FIFO read-clock domain, drains the show-ahead FIFO read port in fixed-length bursts, and presents the words as a registered valid/ready stream with start-of-burst and end-of-burst markers. A burst starts only when the FIFO holds enough words to complete it, so the stream never stalls mid-burst for lack of data. An optional timeout flushes a partial burst.

## Interface
- DATA_WIDTH, 8, word width; must match the FIFO.
- WORDS_AMOUNT, 8, FIFO depth in words.
- ADDR_WIDTH, $clog2(WORDS_AMOUNT), FIFO address width.
- BURST_LEN, 4, words per full burst; legal range 1..WORDS_AMOUNT.
- TIMEOUT_CYCLES, 16, idle cycles before a partial flush (used only with FLUSH_TIMEOUT_EN); must be ≥ 1.

Ports:
- clk_i  in  1  clock, which is the FIFO read clock.
- rst_i  in  1  reset; asynchronous, active-high.
- fifo_data_i  in  DATA_WIDTH  FIFO rd_data; valid whenever fifo_empty_i = 0 (show-ahead).
- fifo_empty_i  in  1  FIFO rd_empty.
- fifo_used_words_i  in  ADDR_WIDTH+1  FIFO rd_used_words; excludes the word already presented at the FIFO output.
- fifo_rd_o  out  1  FIFO rd request; pops the presented word.
- data_o  out  DATA_WIDTH  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.
- sop_o  out  1  first word of a burst; qualified by valid_o.
- eop_o  out  1  last word of a burst; qualified by valid_o.
- busy_o  out  1  a burst is in progress or the output register is occupied.

## Operation
- Available word count: avail = fifo_used_words_i + !fifo_empty_i, computed at ADDR_WIDTH+2 bits with no truncation.
- The FSM has two states, IDLE and BURST.
- IDLE → BURST when avail ≥ BURST_LEN.
  - On this transition: len_q = BURST_LEN and cnt = 0.
  - No pop is issued in the transition cycle.
- BURST, pop condition: pop = !fifo_empty_i && (!valid_o || ready_i). fifo_rd_o = pop. fifo_rd_o is never asserted in IDLE.
- BURST, on each pop:
  - data_o ← fifo_data_i and valid_o ← 1.
  - sop_o ← (cnt == 0) and eop_o ← (cnt == len_q−1).
  - cnt ← cnt+1.
- BURST → IDLE on the pop where cnt == len_q−1.
- Output register:
  - valid_o clears when valid_o && ready_i and there is no pop in the same cycle.
  - data_o, sop_o and eop_o hold while valid_o && !ready_i.
- Simultaneous events:
  - Handshake and pop in the same cycle: the register reloads and valid_o stays 1.
  - Return to IDLE while the last word is still unaccepted: a new burst may start. Its first pop waits for ready_i, per the pop rule.
- If fifo_empty_i asserts mid-burst (not expected when the FIFO has a single reader), pops pause. cnt holds and the burst resumes when data returns.
- busy_o = (state == BURST) || valid_o.
- Reset mid-burst: the FSM returns to IDLE, cnt and timer clear, and the output register is discarded. Words already popped are lost; unpopped words remain in the FIFO.

## Timing
- Reset values: fifo_rd_o = 0, data_o = 0, valid_o = 0, sop_o = 0, eop_o = 0, busy_o = 0. The FSM is in IDLE with cnt = 0 and timer = 0.
- Start latency: avail reaches BURST_LEN in cycle N → state = BURST in N+1 → first pop in N+1 → valid_o = 1 with sop_o in N+2.
- Throughput: with ready_i held at 1, one word per cycle. A burst of L words occupies L consecutive valid_o cycles.
- fifo_rd_o is a combinational output of registered state, fifo_empty_i, valid_o and ready_i. There is a single combinational path from ready_i to fifo_rd_o.
- Minimum gap between bursts: one cycle, the IDLE evaluation cycle.

## Configuration
- FLUSH_TIMEOUT_EN defined:
  - In IDLE, timer increments while !fifo_empty_i && avail < BURST_LEN.
  - timer clears when the FIFO is empty, on entering BURST, and on reset.
  - When timer == TIMEOUT_CYCLES−1: go to BURST with len_q = avail (1..BURST_LEN−1). eop_o marks that short burst's last word.
  - A full-burst condition in the same cycle takes priority, giving len_q = BURST_LEN.
- FLUSH_TIMEOUT_EN undefined:
  - No timer logic; len_q is always BURST_LEN.
  - Fewer than BURST_LEN words stay in the FIFO indefinitely.

## Test plan
- BURST_LEN=4: write 4 words 0xA0..0xA3 with ready_i=1 → valid_o for 4 consecutive cycles with data A0..A3. sop_o on A0, eop_o on A3. fifo_rd_o pulses exactly 4 times.
- Write 3 words without the macro → valid_o stays 0 for 1000 cycles. Write a 4th word → the 4-word burst follows.
- ready_i toggling 1,0,0,1 during a burst → data_o and sop_o/eop_o hold while ready_i=0. No word is lost or duplicated, and no pop occurs while valid_o && !ready_i.
- Write 9 words at once → two back-to-back 4-word bursts (sop/eop on words 0,3 and 4,7). Word 8 remains; fifo_used_words_i + !fifo_empty_i = 1.
- With FLUSH_TIMEOUT_EN and TIMEOUT_CYCLES=16: write 2 words 0x11, 0x22 → after 16 idle cycles, a 2-word burst: sop_o on 0x11, eop_o on 0x22.
- Assert rst_i for one cycle after the 2nd word of a burst → all outputs 0 immediately. After release, the FIFO's remaining words form the next burst once avail ≥ 4.
